// File: rtl/gsim_ctrl.sv
// Sequencing controller for the GSIM Gauss-Seidel solver: loads b, clears x,
// issues row updates sweep by sweep, decides termination and streams x out.
module gsim_ctrl #(
   parameter int N        = 16,
   parameter int AW       = 4,
   parameter int IW       = 8,
   parameter int ITER_MIN = 2,
   parameter int ITER_MAX = 64,
   parameter int TIMEOUT  = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_en,
   output logic          b_we,
   output logic [AW-1:0] b_waddr,
   output logic          x_we,
   output logic          x_clr,
   output logic [AW-1:0] x_waddr,
   output logic          x_re,
   output logic [AW-1:0] x_raddr,
   output logic          dp_start,
   output logic [AW-1:0] dp_row,
   input  logic          dp_done,
   input  logic          dp_small,
   output logic          out_valid,
   output logic          busy,
   output logic          converged,
   output logic          err,
   output logic [IW-1:0] iter_cnt
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW-1:0] LAST       = AW'(N - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [IW-1:0] ITER_MIN_V = IW'(ITER_MIN);
   localparam logic [IW-1:0] ITER_MAX_V = IW'(ITER_MAX);

   typedef enum logic [2:0] {IDLE, LOAD, INIT, ISSUE, WAIT, SWEEP_END, OUT} state_t;

   state_t        state, state_next;
   logic [AW-1:0] cnt;        // load, x-clear and readout address
   logic [AW-1:0] row;
   logic [TW-1:0] tmo;        // cycles elapsed since dp_start
   logic          all_small;
   logic [IW-1:0] iter_inc;

   assign iter_inc = iter_cnt + IW'(1);

   // NOTE: every output and state_next gets a default first so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      b_we       = 1'b0;
      b_waddr    = '0;
      x_we       = 1'b0;
      x_clr      = 1'b0;
      x_waddr    = '0;
      x_re       = 1'b0;
      x_raddr    = '0;
      dp_start   = 1'b0;
      dp_row     = '0;
      busy       = (state != IDLE) || out_valid;
      case (state)
         IDLE: begin
            b_we    = in_en;
            b_waddr = cnt;
            if (in_en) state_next = LOAD;
         end
         LOAD: begin
            b_we    = in_en;
            b_waddr = cnt;
            if (in_en && cnt == LAST) state_next = INIT;
         end
         INIT: begin
            x_we    = 1'b1;
            x_clr   = 1'b1;
            x_waddr = cnt;
            if (cnt == LAST) state_next = ISSUE;
         end
         ISSUE: begin
            dp_start   = 1'b1;
            dp_row     = row;
            state_next = WAIT;
         end
         WAIT: begin
            dp_row = row;
            if (dp_done) begin
               x_we       = 1'b1;
               x_waddr    = row;
               state_next = (row == LAST) ? SWEEP_END : ISSUE;
            end else if (tmo == TMO_LAST) begin
               state_next = OUT;
            end
         end
         SWEEP_END: begin
            if ((all_small && iter_inc >= ITER_MIN_V) || iter_inc == ITER_MAX_V)
               state_next = OUT;
            else
               state_next = ISSUE;
         end
         OUT: begin
            x_re    = 1'b1;
            x_raddr = cnt;
            if (cnt == LAST) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         row       <= '0;
         tmo       <= '0;
         all_small <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         out_valid <= (state == OUT);
         case (state)
            LOAD:  if (in_en) cnt <= cnt + AW'(1);
            INIT: begin
               cnt <= cnt + AW'(1);
               if (cnt == LAST) begin
                  row       <= '0;
                  all_small <= 1'b1;
               end
            end
            ISSUE: tmo <= TW'(1);
            WAIT: begin
               if (dp_done) begin
                  all_small <= all_small & dp_small;
                  if (row != LAST) row <= row + AW'(1);
               end else begin
                  tmo <= tmo + TW'(1);
               end
            end
            SWEEP_END: begin
               row       <= '0;
               all_small <= 1'b1;
            end
            OUT:   cnt <= cnt + AW'(1);
            default: if (in_en) cnt <= AW'(1);
         endcase
      end
   end

   // NOTE: these result flags deliberately skip reset; they hold the last run's outcome until a new load.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (state == IDLE && in_en) begin
            converged <= 1'b0;
            err       <= 1'b0;
            iter_cnt  <= '0;
         end else if (state == WAIT && !dp_done && tmo == TMO_LAST) begin
            err <= 1'b1;
         end else if (state == SWEEP_END) begin
            iter_cnt <= iter_inc;
            if (all_small && iter_inc >= ITER_MIN_V) converged <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gsim_ctrl.sv
// Directed bench for gsim_ctrl: load/clear sequencing, sweep issue order,
// convergence, iteration cap, timeout and result streaming.
module tb_gsim_ctrl;
   localparam int N  = 16;
   localparam int AW = 4;
   localparam int IW = 8;

   logic          clk = 1'b0, reset = 1'b0, in_en = 1'b0;
   logic          dp_done = 1'b0, dp_small = 1'b0;
   logic          b_we, x_we, x_clr, x_re, dp_start, out_valid, busy, converged, err;
   logic [AW-1:0] b_waddr, x_waddr, x_raddr, dp_row;
   logic [IW-1:0] iter_cnt;

   gsim_ctrl #(.N(N), .AW(AW), .IW(IW), .ITER_MIN(2), .ITER_MAX(8), .TIMEOUT(32)) dut (
      .clk(clk), .reset(reset), .in_en(in_en),
      .b_we(b_we), .b_waddr(b_waddr),
      .x_we(x_we), .x_clr(x_clr), .x_waddr(x_waddr),
      .x_re(x_re), .x_raddr(x_raddr),
      .dp_start(dp_start), .dp_row(dp_row), .dp_done(dp_done), .dp_small(dp_small),
      .out_valid(out_valid), .busy(busy), .converged(converged), .err(err), .iter_cnt(iter_cnt)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;

   // Monitor state, written only by the negedge monitor.
   int cyc = 0, bw_cnt = 0, bw_bad = 0, clr_cnt = 0, clr_bad = 0, clr_last_cyc = 0;
   int st_cnt = 0, st_bad = 0, st_last_cyc = 0, run_starts = 0;
   int wr_cnt = 0, wr_bad = 0, ov_cnt = 0, ov_bad = 0, ov_runs = 0, busy_bad = 0, err_rise_cyc = -1;
   logic [AW-1:0] last_row = '0, prev_raddr = '0;
   logic prev_re = 1'b0, prev_ov = 1'b0, prev_err = 1'b0, pend_small = 1'b0;

   // Stimulus controls, written only by the initial block.
   bit dp_en = 1'b0;
   int small_mode = 0;

   // Datapath model state, written only by the driver.
   int cd = 0, served = 0;

   function automatic logic small_of(input int mode, input int sweep, input int r);
      case (mode)
         1:       return 1'b1;
         2:       return !(sweep == 2 && r == 7);
         default: return 1'b0;
      endcase
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (b_we) begin
         if (b_waddr != AW'(bw_cnt % N)) bw_bad++;
         bw_cnt++;
      end
      if (x_we && x_clr) begin
         if (x_waddr != AW'(clr_cnt % N)) clr_bad++;
         clr_cnt++;
         clr_last_cyc = cyc;
         run_starts   = 0;
      end
      if (x_we && !x_clr) begin
         if (!dp_done || x_waddr != last_row) wr_bad++;
         wr_cnt++;
      end
      if (dp_start) begin
         if (dp_row != AW'(run_starts % N)) st_bad++;
         pend_small  = small_of(small_mode, run_starts / N + 1, run_starts % N);
         last_row    = dp_row;
         st_last_cyc = cyc;
         run_starts++;
         st_cnt++;
      end
      if (out_valid) begin
         if (!prev_re || prev_raddr != AW'(ov_cnt % N)) ov_bad++;
         if (!prev_ov) ov_runs++;
         ov_cnt++;
      end
      if (out_valid && !busy) busy_bad++;
      if (prev_ov && !out_valid && busy) busy_bad++;
      if (err && !prev_err) err_rise_cyc = cyc;
      prev_re    = x_re;
      prev_raddr = x_raddr;
      prev_ov    = out_valid;
      prev_err   = err;
   end

   // Datapath model: dp_done pulses 4 cycles after each dp_start.
   always @(posedge clk) begin
      #1;
      dp_done  = 1'b0;
      dp_small = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            dp_done  = 1'b1;
            dp_small = pend_small;
         end
      end
      if (st_cnt != served) begin
         served = st_cnt;
         if (dp_en) cd = 3;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      in_en = 1'b0;
      repeat (3) tick;
      tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (b_we !== 1'b0)      begin fails++; $display("FAIL reset_b_we: got %b want 0", b_we); end
      tests++; if (x_we !== 1'b0)      begin fails++; $display("FAIL reset_x_we: got %b want 0", x_we); end
      tests++; if (x_re !== 1'b0)      begin fails++; $display("FAIL reset_x_re: got %b want 0", x_re); end
      tests++; if (dp_start !== 1'b0)  begin fails++; $display("FAIL reset_dp_start: got %b want 0", dp_start); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      reset = 1'b1;
      tick;
   endtask

   task automatic test_load_contig;
      int s_bw = bw_cnt, s_bwb = bw_bad, s_clr = clr_cnt, s_clrb = clr_bad, s_stb = st_bad;
      dp_en = 1'b0;
      for (int w = 0; w < N; w++) begin
         in_en = 1'b1;
         tick;
         if (w == 0) begin
            tests++; if (iter_cnt !== '0 || converged !== 1'b0 || err !== 1'b0)
               begin fails++; $display("FAIL load_clear_flags: got iter=%0d conv=%b err=%b want 0 0 0", iter_cnt, converged, err); end
         end
      end
      in_en = 1'b0;
      for (int i = 0; i < 40 && !dp_start; i++) tick;
      tests++; if (dp_start !== 1'b1) begin fails++; $display("FAIL contig_first_start: got %b want 1", dp_start); end
      tests++; if (dp_row !== '0)     begin fails++; $display("FAIL contig_first_row: got %0d want 0", dp_row); end
      tick;
      tests++; if (bw_cnt - s_bw != 16) begin fails++; $display("FAIL contig_b_writes: got %0d want 16", bw_cnt - s_bw); end
      tests++; if (bw_bad != s_bwb)     begin fails++; $display("FAIL contig_b_addr: got %0d bad want 0", bw_bad - s_bwb); end
      tests++; if (clr_cnt - s_clr != 16) begin fails++; $display("FAIL contig_x_clears: got %0d want 16", clr_cnt - s_clr); end
      tests++; if (clr_bad != s_clrb)   begin fails++; $display("FAIL contig_clr_addr: got %0d bad want 0", clr_bad - s_clrb); end
      tests++; if (st_last_cyc - clr_last_cyc != 1)
         begin fails++; $display("FAIL contig_start_latency: got %0d want 1", st_last_cyc - clr_last_cyc); end
      tests++; if (st_bad != s_stb)     begin fails++; $display("FAIL contig_row: got %0d bad want 0", st_bad - s_stb); end
   endtask

   task automatic test_reset_mid_wait;
      repeat (3) tick;
      reset = 1'b0;
      tick;
      tests++; if (busy !== 1'b0 || dp_start !== 1'b0 || x_we !== 1'b0)
         begin fails++; $display("FAIL midreset_outputs: got busy=%b dp_start=%b x_we=%b want 0 0 0", busy, dp_start, x_we); end
      tick;
      reset = 1'b1;
      tests++; if (busy !== 1'b0 || x_re !== 1'b0 || out_valid !== 1'b0 || b_we !== 1'b0 || dp_row !== '0)
         begin fails++; $display("FAIL midreset_idle: got busy=%b x_re=%b ov=%b b_we=%b row=%0d want all 0", busy, x_re, out_valid, b_we, dp_row); end
      tick;
   endtask

   task automatic test_cap;
      int s_bw = bw_cnt, s_bwb = bw_bad, s_clr = clr_cnt, s_st = st_cnt, s_stb = st_bad;
      int s_wr = wr_cnt, s_wrb = wr_bad, s_ov = ov_cnt, s_ovb = ov_bad, s_runs = ov_runs, s_bb = busy_bad;
      bit ok;
      dp_en = 1'b1;
      small_mode = 0;
      for (int w = 0; w < N; w++) begin
         if (w == 5) begin
            for (int g = 0; g < 3; g++) begin
               in_en = 1'b0;
               #3;
               tests++; if (b_waddr !== AW'(5) || b_we !== 1'b0)
                  begin fails++; $display("FAIL gap_hold: got addr=%0d we=%b want 5 0", b_waddr, b_we); end
               tick;
            end
         end
         in_en = 1'b1;
         if (w == N - 1) begin
            #1;
            tests++; if (x_we !== 1'b0 || b_waddr !== AW'(15))
               begin fails++; $display("FAIL gap_init_early: got x_we=%b addr=%0d want 0 15", x_we, b_waddr); end
         end
         tick;
      end
      in_en = 1'b0;
      tests++; if (x_we !== 1'b1 || x_clr !== 1'b1 || x_waddr !== '0)
         begin fails++; $display("FAIL gap_init_start: got we=%b clr=%b addr=%0d want 1 1 0", x_we, x_clr, x_waddr); end
      wait_idle(3000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL cap_timeout: got busy=%b want 0", busy); end
      tests++; if (bw_cnt - s_bw != 16)    begin fails++; $display("FAIL cap_b_writes: got %0d want 16", bw_cnt - s_bw); end
      tests++; if (bw_bad != s_bwb)        begin fails++; $display("FAIL cap_b_addr: got %0d bad want 0", bw_bad - s_bwb); end
      tests++; if (clr_cnt - s_clr != 16)  begin fails++; $display("FAIL cap_x_clears: got %0d want 16", clr_cnt - s_clr); end
      tests++; if (st_cnt - s_st != 128)   begin fails++; $display("FAIL cap_starts: got %0d want 128", st_cnt - s_st); end
      tests++; if (st_bad != s_stb)        begin fails++; $display("FAIL cap_rows: got %0d bad want 0", st_bad - s_stb); end
      tests++; if (wr_cnt - s_wr != 128)   begin fails++; $display("FAIL cap_x_writes: got %0d want 128", wr_cnt - s_wr); end
      tests++; if (wr_bad != s_wrb)        begin fails++; $display("FAIL cap_x_waddr: got %0d bad want 0", wr_bad - s_wrb); end
      tests++; if (iter_cnt !== IW'(8))    begin fails++; $display("FAIL cap_iter: got %0d want 8", iter_cnt); end
      tests++; if (converged !== 1'b0 || err !== 1'b0)
         begin fails++; $display("FAIL cap_flags: got conv=%b err=%b want 0 0", converged, err); end
      tests++; if (ov_cnt - s_ov != 16)    begin fails++; $display("FAIL cap_beats: got %0d want 16", ov_cnt - s_ov); end
      tests++; if (ov_bad != s_ovb)        begin fails++; $display("FAIL cap_raddr: got %0d bad want 0", ov_bad - s_ovb); end
      tests++; if (ov_runs - s_runs != 1)  begin fails++; $display("FAIL cap_beat_runs: got %0d want 1", ov_runs - s_runs); end
      tests++; if (busy_bad != s_bb)       begin fails++; $display("FAIL cap_busy_drop: got %0d bad want 0", busy_bad - s_bb); end
   endtask

   task automatic test_converge(input int mode, input int exp_iter, input int prev_iter);
      int s_st = st_cnt, s_wr = wr_cnt, s_ov = ov_cnt, s_ovb = ov_bad;
      bit ok;
      dp_en = 1'b1;
      small_mode = mode;
      tests++; if (iter_cnt !== IW'(prev_iter))
         begin fails++; $display("FAIL conv%0d_iter_hold: got %0d want %0d", mode, iter_cnt, prev_iter); end
      for (int w = 0; w < N; w++) begin
         in_en = 1'b1;
         tick;
         if (w == 0) begin
            tests++; if (iter_cnt !== '0 || converged !== 1'b0)
               begin fails++; $display("FAIL conv%0d_clear: got iter=%0d conv=%b want 0 0", mode, iter_cnt, converged); end
         end
      end
      in_en = 1'b0;
      wait_idle(3000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL conv%0d_timeout: got busy=%b want 0", mode, busy); end
      tests++; if (st_cnt - s_st != 16 * exp_iter)
         begin fails++; $display("FAIL conv%0d_starts: got %0d want %0d", mode, st_cnt - s_st, 16 * exp_iter); end
      tests++; if (wr_cnt - s_wr != 16 * exp_iter)
         begin fails++; $display("FAIL conv%0d_writes: got %0d want %0d", mode, wr_cnt - s_wr, 16 * exp_iter); end
      tests++; if (iter_cnt !== IW'(exp_iter))
         begin fails++; $display("FAIL conv%0d_iter: got %0d want %0d", mode, iter_cnt, exp_iter); end
      tests++; if (converged !== 1'b1 || err !== 1'b0)
         begin fails++; $display("FAIL conv%0d_flags: got conv=%b err=%b want 1 0", mode, converged, err); end
      tests++; if (ov_cnt - s_ov != 16 || ov_bad != s_ovb)
         begin fails++; $display("FAIL conv%0d_beats: got %0d beats %0d bad want 16 0", mode, ov_cnt - s_ov, ov_bad - s_ovb); end
   endtask

   task automatic test_timeout;
      int s_st = st_cnt, s_wr = wr_cnt, s_ov = ov_cnt, s_ovb = ov_bad, s_bb = busy_bad;
      bit ok;
      dp_en = 1'b0;
      for (int w = 0; w < N; w++) begin
         in_en = 1'b1;
         tick;
      end
      in_en = 1'b0;
      wait_idle(500, ok);
      tests++; if (!ok) begin fails++; $display("FAIL tmo_stuck: got busy=%b want 0", busy); end
      tests++; if (err !== 1'b1)            begin fails++; $display("FAIL tmo_err: got %b want 1", err); end
      tests++; if (err_rise_cyc - st_last_cyc != 32)
         begin fails++; $display("FAIL tmo_latency: got %0d want 32", err_rise_cyc - st_last_cyc); end
      tests++; if (st_cnt - s_st != 1)      begin fails++; $display("FAIL tmo_starts: got %0d want 1", st_cnt - s_st); end
      tests++; if (wr_cnt != s_wr)          begin fails++; $display("FAIL tmo_x_write: got %0d want 0", wr_cnt - s_wr); end
      tests++; if (ov_cnt - s_ov != 16 || ov_bad != s_ovb)
         begin fails++; $display("FAIL tmo_beats: got %0d beats %0d bad want 16 0", ov_cnt - s_ov, ov_bad - s_ovb); end
      tests++; if (converged !== 1'b0 || iter_cnt !== '0)
         begin fails++; $display("FAIL tmo_flags: got conv=%b iter=%0d want 0 0", converged, iter_cnt); end
      tests++; if (busy_bad != s_bb)        begin fails++; $display("FAIL tmo_busy_drop: got %0d bad want 0", busy_bad - s_bb); end
   endtask

   initial begin
      test_reset;
      test_load_contig;
      test_reset_mid_wait;
      test_cap;
      test_converge(1, 2, 8);
      test_converge(2, 3, 2);
      test_timeout;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gsim_ctrl.md
Name: gsim_ctrl

Overview:
- Sequencing controller for the GSIM Gauss-Seidel solver datapath. The system is a 16x16 banded system: diagonal 20, off-diagonals -13, 6, -1; b is 16-bit signed; x is 32-bit 16.16 fixed point.
- Collects the 16 b words into b memory and zero-initialises x memory.
- Issues row-by-row update commands to the arithmetic datapath, counts sweeps, and decides termination on convergence, iteration cap or timeout.
- Streams the 16 results out to the GSIM top level as out_valid beats.

Parameters:
N, 16, number of unknowns/rows (power of 2)
AW, 4, address width, log2(N)
IW, 8, iteration counter width
ITER_MIN, 2, minimum completed sweeps before convergence may terminate
ITER_MAX, 64, hard sweep cap (1..2^IW-1)
TIMEOUT, 32, max cycles from dp_start to dp_done

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
in_en  in  1  b word valid this cycle
b_we  out  1  b memory write enable
b_waddr  out  AW  b memory write address
x_we  out  1  x memory write enable
x_clr  out  1  x write data select: 1 = zero, 0 = datapath result
x_waddr  out  AW  x memory write address
x_re  out  1  x memory read enable (output phase)
x_raddr  out  AW  x memory read address (output phase)
dp_start  out  1  one-cycle pulse: update row dp_row
dp_row  out  AW  row index being updated
dp_done  in  1  datapath result ready (single-cycle pulse)
dp_small  in  1  valid with dp_done: |x_new - x_old| below threshold
out_valid  out  1  x_out valid (x_out itself comes from x memory)
busy  out  1  high in every state except IDLE
converged  out  1  sticky: terminated by convergence
err  out  1  sticky: terminated by timeout
iter_cnt  out  IW  completed sweeps

Behaviour:
- Reset (reset==0 at clk edge) has priority over everything, including mid-operation:
  - State goes to IDLE; all counters clear.
  - All outputs are 0. converged, err and iter_cnt hold until the next LOAD entry and clear there.
- States: IDLE, LOAD, INIT, ISSUE, WAIT, SWEEP_END, OUT.
- b_we and b_waddr: b_we = in_en while in IDLE or LOAD (combinational); b_waddr = load counter.
  - in_en in any other state is ignored (b_we=0).
- IDLE: in_en=1 writes word 0 and moves to LOAD; load counter becomes 1; converged, err and iter_cnt clear.
- LOAD:
  - Each in_en=1 cycle writes at the counter and increments it.
  - in_en=0 gaps hold the counter.
  - The write at address N-1 moves to INIT.
- INIT: N cycles with x_we=1, x_clr=1, x_waddr 0..N-1, then ISSUE with row=0.
- ISSUE: dp_start=1 for exactly one cycle, dp_row=row; timeout counter clears; go to WAIT.
- WAIT:
  - dp_row holds.
  - On dp_done: x_we=1, x_clr=0, x_waddr=row, all in the same cycle (combinational). Sweep flag all_small &= dp_small.
  - Then, if row==N-1, go to SWEEP_END; else row+1 and ISSUE.
  - dp_done outside WAIT is ignored.
  - If dp_done is not seen within TIMEOUT cycles: err=1, go to OUT, no x write.
- SWEEP_END (1 cycle): iter_cnt+1, evaluated on the new value:
  - all_small && iter_cnt>=ITER_MIN: converged=1, go to OUT.
  - Else if iter_cnt==ITER_MAX: go to OUT.
  - Else: row=0, all_small=1, go to ISSUE.
  - all_small is set to 1 on entry to each sweep.
  - Convergence wins if both conditions hold; converged stays 0 on cap termination.
- Worst-case sweep length: N*(2+DP latency) cycles. Gauss-Seidel ordering is guaranteed by never issuing row r+1 before row r is written.
- OUT:
  - N consecutive cycles with x_re=1, x_raddr 0..N-1.
  - x memory has 1-cycle read latency, so out_valid is registered: high exactly N consecutive cycles starting one cycle after the first x_re.
  - After the last beat, go to IDLE; busy drops with the last out_valid.
- Counters wrap cleanly at N (AW bits); no out-of-range addresses are ever driven.

Test Plan:
- Reset mid-WAIT (reset=0 for 2 cycles) -> all outputs 0, state IDLE; next load starts at b_waddr=0 and re-zeroes x.
- 16 contiguous in_en words -> b_we high 16 cycles, b_waddr 0..15; then 16 cycles x_we=x_clr=1, x_waddr 0..15; first dp_start with dp_row=0 on the next cycle.
- Load with in_en low for 3 cycles after word 5 -> words 0..4 at addresses 0..4; b_waddr holds 5 through the gap; exactly 16 writes total; INIT only after address 15.
- Datapath model: dp_done 4 cycles after dp_start, dp_small=0, ITER_MAX=8 -> 128 dp_start pulses (rows 0..15 repeating), 128 x writes at x_waddr=dp_row, iter_cnt=8, converged=0, err=0, then 16 consecutive out_valid with x_raddr 0..15 one cycle earlier.
- Same model, dp_small=1 from sweep 1 onward, ITER_MIN=2 -> terminates after sweep 2: iter_cnt=2, converged=1. With dp_small=0 on row 7 of sweep 2 -> terminates after sweep 3: iter_cnt=3.
- dp_done never returned, TIMEOUT=32 -> exactly 32 cycles after the first dp_start: err=1, no x_we with x_clr=0, 16 out_valid beats, then busy=0.
